cond_it_unit: RTL and testbench

- Execute-stage conditional-execution unit for the combined ARM/RISC-V core.
- Owns the architectural NZCV flag register and a parametrised IT-block (If-Then) sequencer.
- Evaluates the effective condition of the instruction in E and gates its register, memory, PC and branch side effects.
- Successor to the combinational condition logic: flags and IT state are now held here, and IT blocks are supported.

---
 rtl/cond_pkg.sv | 25 ++
 rtl/cond_eval.sv | 41 ++++
 rtl/cond_it_unit.sv | 102 ++++++++++
 tb/tb_cond_it_unit.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// Shared types and constants for ARM/RISC-V condition evaluation and IT-block state.
// Used by the execute-stage unit and by the decode-stage predictor.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
        MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
        HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
        GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
    } cond_t;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    // Reference layout at the default depth; for depth 4 {base, bits} equals ITSTATE[7:0].
    localparam int IT_DEPTH_DEF = 4;

    typedef struct packed {
        logic [2:0]            base;
        logic [IT_DEPTH_DEF:0] bits;
    } it_state_t;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator: cond + NZCV -> pass.
// Zero latency, no flow control; NV and any unknown code evaluate to 0.
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    always_comb begin
        pass = 1'b0;
        case (cond_t'(cond))
            EQ: pass = z;
            NE: pass = ~z;
            CS: pass = c;
            CC: pass = ~c;
            MI: pass = n;
            PL: pass = ~n;
            VS: pass = v;
            VC: pass = ~v;
            HI: pass = c & ~z;
            LS: pass = ~c | z;
            GE: pass = (n == v);
            LT: pass = (n != v);
            GT: pass = ~z & (n == v);
            LE: pass = z | (n != v);
            AL: pass = 1'b1;
            NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_it_unit.sv
// Execute-stage conditional execution: owns NZCV and the IT sequencer, gates E-stage side effects.
// Outputs are combinational from E inputs and held state; state updates only on an uncommitted-free commit.
module cond_it_unit
    import cond_pkg::*;
#(
    parameter int ITDEPTH = 4,
    parameter int FLAGW   = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               validE,
    input  logic               stallE,
    input  logic               flushE,
    input  logic               armE,
    input  logic [3:0]         CondE,
    input  logic [FLAGW-1:0]   ALUFlags,
    input  logic [1:0]         FlagWriteE,
    input  logic               RegWrite,
    input  logic               MemWrite,
    input  logic               PCSrc,
    input  logic [1:0]         BranchE,
    input  logic               itStartE,
    input  logic [3:0]         itFirstCondE,
    input  logic [ITDEPTH-1:0] itMaskE,
    output logic               RegWriteE_ARM,
    output logic               MemWriteE_ARM,
    output logic               PCSrcE,
    output logic [1:0]         BranchTakenE,
    output logic               CondExE,
    output logic [FLAGW-1:0]   FlagsQ,
    output logic               itActive
);

    typedef struct packed {
        logic [2:0]       base;
        logic [ITDEPTH:0] bits;
    } it_st_t;

    it_st_t           it_q;
    logic [FLAGW-1:0] flags_q;
    logic [3:0]       it_cond;
    logic [3:0]       eff_cond;
    logic [3:0]       src_flags;
    logic             pass;
    logic             it_conflict;
    logic             commit;
    logic             gate;
    logic             flag_wr;
    logic             it_load;
    logic             it_adv;

    assign itActive = |it_q.bits[ITDEPTH-1:0];
    assign it_cond  = {it_q.base, it_q.bits[ITDEPTH]};
    assign FlagsQ   = flags_q;

    assign eff_cond  = (armE && itActive) ? it_cond : CondE;
    // RISC-V compare-branches test the flags produced by their own ALU op.
    assign src_flags = armE ? flags_q[3:0] : ALUFlags[3:0];

    cond_eval u_cond_eval (
        .cond  (eff_cond),
        .flags (src_flags),
        .pass  (pass)
    );

    // A nested IT inside an active block is not architecturally allowed; squash it.
    assign it_conflict = armE & itActive & itStartE;
    assign CondExE     = validE & pass & ~it_conflict;

    assign commit = validE & ~stallE & ~flushE;
    assign gate   = CondExE & validE & ~flushE;

    assign RegWriteE_ARM = RegWrite & gate;
    assign MemWriteE_ARM = MemWrite & gate;
    assign PCSrcE        = PCSrc & gate;
    assign BranchTakenE  = BranchE & {2{gate}};

    assign flag_wr = commit & armE & CondExE;
    assign it_load = commit & armE & itStartE & ~itActive & (itMaskE != '0);
    assign it_adv  = commit & armE & itActive & ~itStartE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q <= '0;
            it_q    <= '0;
        end else begin
            if (flag_wr) begin
                if (FlagWriteE[1]) flags_q[N_IDX:Z_IDX] <= ALUFlags[N_IDX:Z_IDX];
                if (FlagWriteE[0]) flags_q[C_IDX:V_IDX] <= ALUFlags[C_IDX:V_IDX];
            end
            if (it_load) begin
                it_q.base <= itFirstCondE[3:1];
                it_q.bits <= {itFirstCondE[0], itMaskE};
            end else if (it_adv) begin
                // Advance even on a failed condition; the trailing 1 marks the last slot.
                if (it_q.bits[ITDEPTH-2:0] == '0) it_q.bits <= '0;
                else                              it_q.bits <= it_q.bits << 1;
            end
        end
    end

endmodule

// File: tb/tb_cond_it_unit.sv
// Directed self-checking bench for cond_it_unit: flags, IT sequencing, stall/flush, RISC-V path, async reset.
module tb_cond_it_unit;

    logic       clk;
    logic       reset_n;
    logic       validE, stallE, flushE, armE;
    logic [3:0] CondE;
    logic [3:0] ALUFlags;
    logic [1:0] FlagWriteE;
    logic       RegWrite, MemWrite, PCSrc;
    logic [1:0] BranchE;
    logic       itStartE;
    logic [3:0] itFirstCondE;
    logic [3:0] itMaskE;
    logic       RegWriteE_ARM, MemWriteE_ARM, PCSrcE;
    logic [1:0] BranchTakenE;
    logic       CondExE;
    logic [3:0] FlagsQ;
    logic       itActive;

    int total = 0;
    int bad   = 0;

    cond_it_unit #(.ITDEPTH(4), .FLAGW(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .validE        (validE),
        .stallE        (stallE),
        .flushE        (flushE),
        .armE          (armE),
        .CondE         (CondE),
        .ALUFlags      (ALUFlags),
        .FlagWriteE    (FlagWriteE),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .PCSrc         (PCSrc),
        .BranchE       (BranchE),
        .itStartE      (itStartE),
        .itFirstCondE  (itFirstCondE),
        .itMaskE       (itMaskE),
        .RegWriteE_ARM (RegWriteE_ARM),
        .MemWriteE_ARM (MemWriteE_ARM),
        .PCSrcE        (PCSrcE),
        .BranchTakenE  (BranchTakenE),
        .CondExE       (CondExE),
        .FlagsQ        (FlagsQ),
        .itActive      (itActive)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr;
        validE = 0; stallE = 0; flushE = 0; armE = 1; CondE = 4'he;
        ALUFlags = 4'b0000; FlagWriteE = 2'b00; RegWrite = 0; MemWrite = 0;
        PCSrc = 0; BranchE = 2'b00; itStartE = 0; itFirstCondE = 4'h0; itMaskE = 4'h0;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // IT EQ with ITTE mask: slots EQ, EQ, NE.
    task automatic load_itte;
        clr; validE = 1; itStartE = 1; itFirstCondE = 4'h0; itMaskE = 4'b0110;
        step;
    endtask

    task automatic test_reset;
        total++; if (FlagsQ !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", FlagsQ); end
        total++; if (itActive !== 1'b0) begin bad++; $display("FAIL reset_itactive got=%b exp=0", itActive); end
        clr; RegWrite = 1; MemWrite = 1; PCSrc = 1; BranchE = 2'b11; #1;
        total++; if ({RegWriteE_ARM, MemWriteE_ARM, PCSrcE, BranchTakenE, CondExE} !== 6'b0) begin
            bad++; $display("FAIL invalid_outputs got=%b exp=000000",
                            {RegWriteE_ARM, MemWriteE_ARM, PCSrcE, BranchTakenE, CondExE});
        end
        validE = 1; flushE = 1; #1;
        total++; if ({RegWriteE_ARM, MemWriteE_ARM, PCSrcE, BranchTakenE} !== 5'b0) begin
            bad++; $display("FAIL flush_outputs got=%b exp=00000",
                            {RegWriteE_ARM, MemWriteE_ARM, PCSrcE, BranchTakenE});
        end
        step;
    endtask

    task automatic test_flags;
        clr; validE = 1; ALUFlags = 4'b0100; FlagWriteE = 2'b11; #1;
        total++; if (CondExE !== 1'b1) begin bad++; $display("FAIL cmp_condex got=%b exp=1", CondExE); end
        step;
        total++; if (FlagsQ !== 4'b0100) begin bad++; $display("FAIL cmp_flags got=%b exp=0100", FlagsQ); end
        clr; validE = 1; CondE = 4'h0; RegWrite = 1; #1;
        total++; if (RegWriteE_ARM !== 1'b1) begin bad++; $display("FAIL eq_dependent got=%b exp=1", RegWriteE_ARM); end
        step;
        clr; validE = 1; CondE = 4'h1; RegWrite = 1; #1;
        total++; if ({RegWriteE_ARM, CondExE} !== 2'b00) begin
            bad++; $display("FAIL ne_dependent got=%b exp=00", {RegWriteE_ARM, CondExE});
        end
        step;
        clr; validE = 1; FlagWriteE = 2'b01; ALUFlags = 4'b1011; step;
        total++; if (FlagsQ !== 4'b0111) begin bad++; $display("FAIL write_cv got=%b exp=0111", FlagsQ); end
        clr; validE = 1; FlagWriteE = 2'b10; ALUFlags = 4'b1000; step;
        total++; if (FlagsQ !== 4'b1011) begin bad++; $display("FAIL write_nz got=%b exp=1011", FlagsQ); end
        clr; validE = 1; FlagWriteE = 2'b11; ALUFlags = 4'b0100; step;
        clr; validE = 1; CondE = 4'h1; FlagWriteE = 2'b11; ALUFlags = 4'b0010; step;
        total++; if (FlagsQ !== 4'b0100) begin bad++; $display("FAIL failed_cond_no_write got=%b exp=0100", FlagsQ); end
    endtask

    task automatic test_it_block;
        clr; validE = 1; itStartE = 1; itFirstCondE = 4'h0; itMaskE = 4'b0110; #1;
        total++; if (CondExE !== 1'b1) begin bad++; $display("FAIL it_own_cond got=%b exp=1", CondExE); end
        step;
        total++; if (itActive !== 1'b1) begin bad++; $display("FAIL it_loaded got=%b exp=1", itActive); end
        for (int i = 0; i < 3; i++) begin
            logic e;
            e = (i < 2);
            clr; validE = 1; CondE = 4'h1; RegWrite = 1; #1;
            total++; if (RegWriteE_ARM !== e) begin bad++; $display("FAIL itte_slot%0d got=%b exp=%b", i, RegWriteE_ARM, e); end
            step;
            total++; if (itActive !== e) begin bad++; $display("FAIL itte_active%0d got=%b exp=%b", i, itActive, e); end
        end
        clr; validE = 1; itStartE = 1; itMaskE = 4'b0000; step;
        total++; if (itActive !== 1'b0) begin bad++; $display("FAIL mask_zero got=%b exp=0", itActive); end
    endtask

    task automatic test_stall_flush;
        load_itte;
        for (int k = 0; k < 2; k++) begin
            clr; validE = 1; stallE = 1; RegWrite = 1; FlagWriteE = 2'b11; #1;
            total++; if (RegWriteE_ARM !== 1'b1) begin bad++; $display("FAIL stall_gate%0d got=%b exp=1", k, RegWriteE_ARM); end
            step;
            total++; if ({FlagsQ, itActive} !== 5'b01001) begin
                bad++; $display("FAIL stall_hold%0d got=%b exp=01001", k, {FlagsQ, itActive});
            end
        end
        clr; validE = 1; stallE = 1; flushE = 1; RegWrite = 1; FlagWriteE = 2'b11; #1;
        total++; if (RegWriteE_ARM !== 1'b0) begin bad++; $display("FAIL flush_gate got=%b exp=0", RegWriteE_ARM); end
        step;
        total++; if ({FlagsQ, itActive} !== 5'b01001) begin
            bad++; $display("FAIL flush_hold got=%b exp=01001", {FlagsQ, itActive});
        end
        for (int i = 0; i < 3; i++) begin
            logic e;
            e = (i < 2);
            clr; validE = 1; CondE = 4'h1; RegWrite = 1; #1;
            total++; if (RegWriteE_ARM !== e) begin bad++; $display("FAIL resume_slot%0d got=%b exp=%b", i, RegWriteE_ARM, e); end
            step;
            total++; if (itActive !== e) begin bad++; $display("FAIL resume_active%0d got=%b exp=%b", i, itActive, e); end
        end
    endtask

    task automatic test_riscv;
        clr; validE = 1; armE = 0; ALUFlags = 4'b0100; CondE = 4'h0; BranchE = 2'b01; FlagWriteE = 2'b11; #1;
        total++; if (BranchTakenE !== 2'b01) begin bad++; $display("FAIL rv_beq got=%b exp=01", BranchTakenE); end
        step;
        clr; validE = 1; armE = 0; ALUFlags = 4'b0000; CondE = 4'h1; BranchE = 2'b01; FlagWriteE = 2'b11; #1;
        total++; if (BranchTakenE !== 2'b01) begin bad++; $display("FAIL rv_bne got=%b exp=01", BranchTakenE); end
        step;
        total++; if (FlagsQ !== 4'b0100) begin bad++; $display("FAIL rv_no_flag_write got=%b exp=0100", FlagsQ); end
        clr; validE = 1; armE = 0; ALUFlags = 4'b0000; CondE = 4'h0; BranchE = 2'b10; #1;
        total++; if (BranchTakenE !== 2'b00) begin bad++; $display("FAIL rv_beq_nt got=%b exp=00", BranchTakenE); end
        step;
        load_itte;
        clr; validE = 1; armE = 0; ALUFlags = 4'b0100; CondE = 4'h1; BranchE = 2'b11; #1;
        total++; if (BranchTakenE !== 2'b00) begin bad++; $display("FAIL rv_in_it got=%b exp=00", BranchTakenE); end
        step;
        total++; if (itActive !== 1'b1) begin bad++; $display("FAIL rv_it_frozen got=%b exp=1", itActive); end
        for (int i = 0; i < 3; i++) begin
            logic e;
            e = (i < 2);
            clr; validE = 1; CondE = 4'h1; RegWrite = 1; #1;
            total++; if (RegWriteE_ARM !== e) begin bad++; $display("FAIL rv_after_slot%0d got=%b exp=%b", i, RegWriteE_ARM, e); end
            step;
        end
    endtask

    task automatic test_nv_nested;
        clr; validE = 1; CondE = 4'hf; MemWrite = 1; #1;
        total++; if ({MemWriteE_ARM, CondExE} !== 2'b00) begin
            bad++; $display("FAIL nv_cond got=%b exp=00", {MemWriteE_ARM, CondExE});
        end
        step;
        load_itte;
        clr; validE = 1; itStartE = 1; itFirstCondE = 4'h1; itMaskE = 4'b1000; RegWrite = 1; #1;
        total++; if ({RegWriteE_ARM, CondExE} !== 2'b00) begin
            bad++; $display("FAIL nested_it got=%b exp=00", {RegWriteE_ARM, CondExE});
        end
        step;
        total++; if (itActive !== 1'b1) begin bad++; $display("FAIL nested_active got=%b exp=1", itActive); end
        for (int i = 0; i < 3; i++) begin
            logic e;
            e = (i < 2);
            clr; validE = 1; CondE = 4'h1; RegWrite = 1; #1;
            total++; if (RegWriteE_ARM !== e) begin bad++; $display("FAIL nested_slot%0d got=%b exp=%b", i, RegWriteE_ARM, e); end
            step;
        end
    endtask

    task automatic test_async_reset;
        load_itte;
        clr; validE = 1; step;
        total++; if ({FlagsQ, itActive} !== 5'b01001) begin
            bad++; $display("FAIL pre_reset got=%b exp=01001", {FlagsQ, itActive});
        end
        #2 reset_n = 0;
        #1;
        total++; if ({FlagsQ, itActive} !== 5'b00000) begin
            bad++; $display("FAIL async_reset got=%b exp=00000", {FlagsQ, itActive});
        end
        step;
        reset_n = 1;
        #1;
        total++; if (itActive !== 1'b0) begin bad++; $display("FAIL post_reset got=%b exp=0", itActive); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 0;
        clr;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1;
        test_reset;
        test_flags;
        test_it_block;
        test_stall_flush;
        test_riscv;
        test_nv_nested;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
